if_stage_fetch: RTL and testbench

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the program counter and issues requests to a variable-latency instruction memory over a req/ack handshake. It presents {PC+4, instruction} to the IF/ID register and handles branch redirects, including a redirect that arrives while a memory request is still outstanding. It asserts fetch_stall whenever no valid instruction is available, so the IF/ID register loads a bubble.

---
 rtl/if_stage_fetch_if.sv | 33 +++
 rtl/if_stage_fetch.sv | 90 +++++++++
 tb/tb_if_stage_fetch.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_fetch_if.sv
// ============================================================================
// Module   : if_stage_fetch_if
// Brief    : Fetch-stage bundle: hazard/redirect inputs, imem handshake, IF/ID outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_stage_fetch_if;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        fetch_stall;

  // master: the fetch stage itself
  modport master (
    input  freeze, branch_taken, branch_addr, imem_ack, imem_rdata,
    output imem_req, imem_addr, pc_out, instruction, fetch_stall
  );

  // slave: pipeline control, instruction memory and IF/ID register
  modport slave (
    output freeze, branch_taken, branch_addr, imem_ack, imem_rdata,
    input  imem_req, imem_addr, pc_out, instruction, fetch_stall
  );
endinterface

`default_nettype wire

// File: rtl/if_stage_fetch.sv
// ============================================================================
// Module   : if_stage_fetch
// Brief    : PC owner and imem requester feeding IF/ID; tracks redirects that
//            land while a memory request is still outstanding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic             clk,
  input  logic             rst,
  if_stage_fetch_if.master bus
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HAVE    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst_buf;
  logic [31:0] r_disc_addr;

  logic        w_valid_now;
  logic [31:0] w_present_inst;
  logic [31:0] w_pc_next;

  assign w_pc_next      = r_pc + PC_INC;
  // rst gates the outputs so they read idle while reset is held
  assign w_valid_now    = ~rst & (((r_state == FETCH) & bus.imem_ack) | (r_state == HAVE));
  assign w_present_inst = (r_state == HAVE) ? r_inst_buf : bus.imem_rdata;

  assign bus.imem_req    = ~rst & (r_state != HAVE);
  assign bus.imem_addr   = (r_state == DISCARD) ? r_disc_addr : r_pc;
  assign bus.fetch_stall = ~w_valid_now;
  assign bus.instruction = w_valid_now ? w_present_inst : 32'h0;
  assign bus.pc_out      = w_valid_now ? w_pc_next : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_inst_buf  <= 32'h0;
      r_disc_addr <= 32'h0;
    end else begin
      case (r_state)
        FETCH: begin
          if (bus.branch_taken && bus.imem_ack) begin
            r_pc <= bus.branch_addr;
          end else if (bus.branch_taken) begin
            // old request must still complete; remember where it was aimed
            r_disc_addr <= r_pc;
            r_pc        <= bus.branch_addr;
            r_state     <= DISCARD;
          end else if (bus.imem_ack && !bus.freeze) begin
            r_pc <= w_pc_next;
          end else if (bus.imem_ack) begin
            r_inst_buf <= bus.imem_rdata;
            r_state    <= HAVE;
          end
        end
        HAVE: begin
          if (bus.branch_taken) begin
            r_pc    <= bus.branch_addr;
            r_state <= FETCH;
          end else if (!bus.freeze) begin
            r_pc    <= w_pc_next;
            r_state <= FETCH;
          end
        end
        DISCARD: begin
          if (bus.branch_taken) begin
            r_pc <= bus.branch_addr;
          end else if (bus.imem_ack) begin
            r_state <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_stage_fetch.sv
// ============================================================================
// Module   : tb_if_stage_fetch
// Brief    : Randomized bench for if_stage_fetch against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_stage_fetch_if bus();

  if_stage_fetch #(.RESET_PC(32'h0000_0000), .PC_INC(32'd4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // behavioural model: what the stage is doing, in plain terms
  logic [31:0] m_pc;
  logic        m_holding;   // an instruction is parked, waiting for freeze to drop
  logic [31:0] m_held;
  logic        m_draining;  // a stale request is still in flight at m_old
  logic [31:0] m_old;

  // memory model
  int  wait_cfg  = 0;       // negative = random latency 0..3
  bit  directed  = 1'b1;    // word = address in directed phase
  bit  mem_armed = 1'b0;
  int  mem_cnt   = 0;

  logic        c_req, c_stall;
  logic [31:0] c_addr, c_inst, c_pc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return directed ? a : ({a[15:0], a[31:16]} ^ 32'h1234_5678);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_holding = 1'b0; m_held = 32'h0;
    m_draining = 1'b0; m_old = 32'h0; mem_armed = 1'b0; mem_cnt = 0;
  endtask

  task automatic step(input logic fr, input logic bt, input logic [31:0] ba);
    logic        ack, e_req, e_valid;
    logic [31:0] e_addr, e_word, e_inst, e_pc;
    @(negedge clk);
    e_req  = !m_holding;
    e_addr = m_draining ? m_old : m_pc;
    ack    = 1'b0;
    if (e_req) begin
      if (!mem_armed) begin
        mem_armed = 1'b1;
        mem_cnt   = (wait_cfg >= 0) ? wait_cfg : int'($urandom_range(0, 3));
      end
      ack = (mem_cnt == 0);
    end
    e_word = word_of(e_addr);
    bus.freeze       = fr;
    bus.branch_taken = bt;
    bus.branch_addr  = ba;
    bus.imem_ack     = ack;
    bus.imem_rdata   = ack ? e_word : $urandom;
    e_valid = m_holding || (!m_draining && ack);
    e_inst  = !e_valid ? 32'h0 : (m_holding ? m_held : e_word);
    e_pc    = e_valid ? m_pc + 32'd4 : 32'h0;
    #1;
    c_req = bus.imem_req; c_addr = bus.imem_addr; c_stall = bus.fetch_stall;
    c_inst = bus.instruction; c_pc = bus.pc_out;
    check32("imem_req", {31'h0, c_req}, {31'h0, e_req});
    if (e_req) check32("imem_addr", c_addr, e_addr);
    check32("fetch_stall", {31'h0, c_stall}, {31'h0, !e_valid});
    check32("instruction", c_inst, e_inst);
    check32("pc_out", c_pc, e_pc);
    @(posedge clk);
    if (mem_armed) begin
      if (ack) mem_armed = 1'b0;
      else     mem_cnt--;
    end
    if (m_draining) begin
      if (bt)       m_pc = ba;
      else if (ack) m_draining = 1'b0;
    end else if (m_holding) begin
      if (bt)       begin m_pc = ba;          m_holding = 1'b0; end
      else if (!fr) begin m_pc = m_pc + 32'd4; m_holding = 1'b0; end
    end else begin
      if (bt) begin
        if (!ack) begin m_old = m_pc; m_draining = 1'b1; end
        m_pc = ba;
      end else if (ack) begin
        if (fr) begin m_held = e_word; m_holding = 1'b1; end
        else    m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.freeze = 1'b0; bus.branch_taken = 1'b0; bus.imem_ack = 1'b0;
    #1;
    check32("rst_req", {31'h0, bus.imem_req}, 32'h0);
    check32("rst_stall", {31'h0, bus.fetch_stall}, 32'h1);
    check32("rst_inst", bus.instruction, 32'h0);
    check32("rst_pc_out", bus.pc_out, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int stalls;
    logic [31:0] ba;
    bus.freeze = 1'b0; bus.branch_taken = 1'b0; bus.branch_addr = 32'h0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
    model_reset();
    apply_reset();

    // zero-wait sequential fetch
    wait_cfg = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0);
      check32("seq_addr", c_addr, 32'(i * 4));
      check32("seq_inst", c_inst, 32'(i * 4));
      check32("seq_pc_out", c_pc, 32'(i * 4 + 4));
      check32("seq_stall", {31'h0, c_stall}, 32'h0);
    end

    // two wait cycles per fetch
    wait_cfg = 2;
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0);
      check32("wait_addr_held", c_addr, 32'h0C);
      stalls += int'(c_stall);
    end
    check32("wait_stall_cycles", 32'(stalls), 32'd2);
    check32("wait_inst", c_inst, 32'h0C);

    // freeze holds instruction 0x10
    wait_cfg = 0;
    step(1'b1, 1'b0, 32'h0);
    check32("frz_inst", c_inst, 32'h10);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0);
      check32("frz_req", {31'h0, c_req}, 32'h0);
      check32("frz_inst_hold", c_inst, 32'h10);
      check32("frz_pc_hold", c_pc, 32'h14);
    end
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check32("frz_next_addr", c_addr, 32'h14);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);

    // redirect during an outstanding request to 0x20
    wait_cfg = 2;
    step(1'b0, 1'b1, 32'h100);
    check32("disc_addr0", c_addr, 32'h20);
    step(1'b0, 1'b0, 32'h0);
    check32("disc_addr1", c_addr, 32'h20);
    step(1'b0, 1'b0, 32'h0);
    check32("disc_addr2", c_addr, 32'h20);
    check32("disc_dropped", c_inst, 32'h0);
    wait_cfg = 0;
    step(1'b0, 1'b0, 32'h0);
    check32("disc_target", c_addr, 32'h100);
    check32("disc_target_inst", c_inst, 32'h100);

    // wrap at top of address space
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0);
    check32("wrap_pc_out", c_pc, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check32("wrap_addr", c_addr, 32'h0);

    // branch beats freeze while holding
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h200);
    step(1'b0, 1'b0, 32'h0);
    check32("br_frz_addr", c_addr, 32'h200);

    // reset in the middle of a wait
    wait_cfg = 3;
    step(1'b0, 1'b0, 32'h0);
    apply_reset();
    wait_cfg = 0;
    step(1'b0, 1'b0, 32'h0);
    check32("post_rst_addr", c_addr, 32'h0);

    // randomized traffic
    directed = 1'b0;
    wait_cfg = -1;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       ba = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
        1:       ba = $urandom;
        default: ba = $urandom & 32'h0000_FFFC;
      endcase
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), ba);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
